// File: rtl/id_exe_pipe_reg_pkg.sv
// Shared types for the ID->EXE stage register: default field widths,
// the packed decode payload, and the skid-buffer occupancy encoding.
// Consumers import this package and may override widths by parameter.
package id_exe_pipe_reg_pkg;

  localparam int DSIZE_DEF = 32;
  localparam int ASIZE_DEF = 5;
  localparam int AOP_W_DEF = 3;

  // Decode payload at default widths, MSB first in the listed order.
  typedef struct packed {
    logic [AOP_W_DEF-1:0] aluop;
    logic                 alusrc;
    logic                 wen;
    logic [DSIZE_DEF-1:0] rdata1;
    logic [DSIZE_DEF-1:0] rdata2;
    logic [DSIZE_DEF-1:0] imm;
    logic [ASIZE_DEF-1:0] waddr;
  } id_exe_pl_t;

  localparam int ID_EXE_PL_W = $bits(id_exe_pl_t);

  // Encoding is {main_v, skid_v}, so bit 1 is the output-valid flag and
  // bit 0 says the overflow entry is occupied.
  typedef enum logic [1:0] {
    SB_EMPTY = 2'b00,
    SB_BUSY  = 2'b10,
    SB_FULL  = 2'b11
  } skid_state_e;

endpackage

// File: rtl/id_exe_pipe_reg_skid_buf.sv
// Generic WIDTH-bit valid/ready stage: 2-entry skid buffer or single register.
// Latency 1 cycle from accept to out_valid when the main entry is free or draining.
// SKID=1: in_ready is a flop (no out_ready->in_ready path); SKID=0: in_ready = out_ready | ~out_valid.
module pipe_skid_buf
  import id_exe_pipe_reg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic accept;
  logic consume;

  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  if (SKID != 0) begin : g_skid

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic [WIDTH-1:0] skid_q, skid_d;
    logic             rdy_q, rdy_d;

    // Occupancy FSM and data steering; flush empties both entries and drops
    // any input accepted in the same cycle. Data only moves on a transfer.
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      if (flush) begin
        state_d = SB_EMPTY;
      end else begin
        case (state_q)
          SB_EMPTY: begin
            if (accept) begin
              state_d = SB_BUSY;
              main_d  = in_data;
            end
          end
          SB_BUSY: begin
            if (accept && consume) begin
              main_d = in_data;
            end else if (accept) begin
              state_d = SB_FULL;
              skid_d  = in_data;
            end else if (consume) begin
              state_d = SB_EMPTY;
            end
          end
          SB_FULL: begin
            if (consume) begin
              state_d = SB_BUSY;
              main_d  = skid_q;
            end
          end
          default: state_d = SB_EMPTY;
        endcase
      end
      // Ready is computed from the next state so the flop always matches ~skid_v.
      rdy_d = (state_d != SB_FULL);
    end

    // State, data and registered ready; reset clears everything and reopens input.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= SB_EMPTY;
        main_q  <= '0;
        skid_q  <= '0;
        rdy_q   <= 1'b1;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
        rdy_q   <= rdy_d;
      end
    end

    assign in_ready  = rdy_q;
    assign out_valid = (state_q != SB_EMPTY);
    assign out_data  = main_q;

  end else begin : g_reg

    logic             vld_q, vld_d;
    logic [WIDTH-1:0] data_q, data_d;

    // Single slot: accept has priority over the drain so back-to-back flows.
    always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      if (flush) begin
        vld_d = 1'b0;
      end else if (accept) begin
        vld_d  = 1'b1;
        data_d = in_data;
      end else if (consume) begin
        vld_d = 1'b0;
      end
    end

    // Valid flag and payload register.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_q  <= 1'b0;
        data_q <= '0;
      end else begin
        vld_q  <= vld_d;
        data_q <= data_d;
      end
    end

    assign in_ready  = out_ready | ~vld_q;
    assign out_valid = vld_q;
    assign out_data  = data_q;

  end

endmodule

// File: rtl/id_exe_pipe_reg.sv
// ID->EXE pipeline register: packs decode fields into one payload, gates wen with valid.
// Latency 1 cycle from accept to the EXE-side outputs.
// Back-pressure via out_ready; flush squashes held and incoming entries; SKID picks skid/plain mode.
module id_exe_pipe_reg
  import id_exe_pipe_reg_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int ASIZE = ASIZE_DEF,
  parameter int AOP_W = AOP_W_DEF,
  parameter int SKID  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AOP_W-1:0] aluop_in,
  input  logic             alusrc_in,
  input  logic             wen_in,
  input  logic [DSIZE-1:0] rdata1_in,
  input  logic [DSIZE-1:0] rdata2_in,
  input  logic [DSIZE-1:0] imm_in,
  input  logic [ASIZE-1:0] waddr_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [AOP_W-1:0] aluop_out,
  output logic             alusrc_out,
  output logic             wen_out,
  output logic [DSIZE-1:0] rdata1_out,
  output logic [DSIZE-1:0] rdata2_out,
  output logic [DSIZE-1:0] imm_out,
  output logic [ASIZE-1:0] waddr_out
);

  // Same field order as the package payload, sized by this instance's parameters.
  typedef struct packed {
    logic [AOP_W-1:0] aluop;
    logic             alusrc;
    logic             wen;
    logic [DSIZE-1:0] rdata1;
    logic [DSIZE-1:0] rdata2;
    logic [DSIZE-1:0] imm;
    logic [ASIZE-1:0] waddr;
  } pl_t;

  localparam int PW = $bits(pl_t);

  pl_t pl_in;
  pl_t pl_out;

  assign pl_in = '{
    aluop:  aluop_in,
    alusrc: alusrc_in,
    wen:    wen_in,
    rdata1: rdata1_in,
    rdata2: rdata2_in,
    imm:    imm_in,
    waddr:  waddr_in
  };

  pipe_skid_buf #(
    .WIDTH (PW),
    .SKID  (SKID)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pl_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (pl_out)
  );

  assign aluop_out  = pl_out.aluop;
  assign alusrc_out = pl_out.alusrc;
  // Stale payload behind a bubble must never reach the register file.
  assign wen_out    = pl_out.wen & out_valid;
  assign rdata1_out = pl_out.rdata1;
  assign rdata2_out = pl_out.rdata2;
  assign imm_out    = pl_out.imm;
  assign waddr_out  = pl_out.waddr;

endmodule

// File: tb/tb_id_exe_pipe_reg.sv
// Directed bench for id_exe_pipe_reg: skid build (dut) and plain build (dut0)
// share stimulus; each scenario checks one build against hand-computed values.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_id_exe_pipe_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [2:0]  aluop_in;
  logic        alusrc_in;
  logic        wen_in;
  logic [31:0] rdata1_in;
  logic [31:0] rdata2_in;
  logic [31:0] imm_in;
  logic [4:0]  waddr_in;

  logic        in_ready, out_valid, alusrc_out, wen_out;
  logic [2:0]  aluop_out;
  logic [31:0] rdata1_out, rdata2_out, imm_out;
  logic [4:0]  waddr_out;

  logic        in_ready0, out_valid0, alusrc_out0, wen_out0;
  logic [2:0]  aluop_out0;
  logic [31:0] rdata1_out0, rdata2_out0, imm_out0;
  logic [4:0]  waddr_out0;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  id_exe_pipe_reg #(.DSIZE(32), .ASIZE(5), .AOP_W(3), .SKID(1)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluop_in(aluop_in), .alusrc_in(alusrc_in), .wen_in(wen_in),
    .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in), .waddr_in(waddr_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .aluop_out(aluop_out), .alusrc_out(alusrc_out), .wen_out(wen_out),
    .rdata1_out(rdata1_out), .rdata2_out(rdata2_out), .imm_out(imm_out), .waddr_out(waddr_out)
  );

  id_exe_pipe_reg #(.DSIZE(32), .ASIZE(5), .AOP_W(3), .SKID(0)) dut0 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready0),
    .aluop_in(aluop_in), .alusrc_in(alusrc_in), .wen_in(wen_in),
    .rdata1_in(rdata1_in), .rdata2_in(rdata2_in), .imm_in(imm_in), .waddr_in(waddr_in),
    .out_valid(out_valid0), .out_ready(out_ready),
    .aluop_out(aluop_out0), .alusrc_out(alusrc_out0), .wen_out(wen_out0),
    .rdata1_out(rdata1_out0), .rdata2_out(rdata2_out0), .imm_out(imm_out0), .waddr_out(waddr_out0)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // All side fields are derived from rdata1 so a single value identifies the entry.
  task automatic drive(input logic v, input logic [31:0] d, input logic w);
    in_valid  = v;
    rdata1_in = d;
    rdata2_in = ~d;
    imm_in    = d ^ 32'h5A5A_5A5A;
    aluop_in  = d[2:0];
    alusrc_in = d[3];
    waddr_in  = d[8:4];
    wen_in    = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // ---------------- reset with garbage on the inputs ----------------
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b1, 32'hFFFF_FFFF, 1'b1);
    tick();
    chk("rst_vld",    32'(out_valid), 32'h0);
    chk("rst_aluop",  32'(aluop_out), 32'h0);
    chk("rst_alusrc", 32'(alusrc_out), 32'h0);
    chk("rst_wen",    32'(wen_out), 32'h0);
    chk("rst_rdata1", rdata1_out, 32'h0);
    chk("rst_rdata2", rdata2_out, 32'h0);
    chk("rst_imm",    imm_out, 32'h0);
    chk("rst_waddr",  32'(waddr_out), 32'h0);
    tick();
    chk("rst2_vld",   32'(out_valid), 32'h0);
    chk("rst2_rdata1", rdata1_out, 32'h0);
    rst = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("post_rst_rdy", 32'(in_ready), 32'h1);
    chk("post_rst_vld", 32'(out_valid), 32'h0);

    // ---------------- streaming ----------------
    out_ready = 1'b1;
    drive(1'b1, 32'h11, 1'b0);
    tick();
    chk("st_vld0",    32'(out_valid), 32'h1);
    chk("st_rdata1_0", rdata1_out, 32'h11);
    chk("st_rdata2_0", rdata2_out, 32'hFFFF_FFEE);
    chk("st_imm_0",   imm_out, 32'h5A5A_5A4B);
    chk("st_aluop_0", 32'(aluop_out), 32'h1);
    chk("st_alusrc_0", 32'(alusrc_out), 32'h0);
    chk("st_waddr_0", 32'(waddr_out), 32'h1);
    chk("st_rdy0",    32'(in_ready), 32'h1);
    drive(1'b1, 32'h22, 1'b1);
    tick();
    chk("st_rdata1_1", rdata1_out, 32'h22);
    chk("st_wen_1",   32'(wen_out), 32'h1);
    chk("st_rdy1",    32'(in_ready), 32'h1);
    drive(1'b1, 32'h33, 1'b0);
    tick();
    chk("st_rdata1_2", rdata1_out, 32'h33);
    chk("st_wen_2",   32'(wen_out), 32'h0);
    chk("st_rdy2",    32'(in_ready), 32'h1);
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("st_drain_vld", 32'(out_valid), 32'h0);

    // ---------------- back-pressure ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'hAAAA_0001, 1'b0);
    tick();
    chk("bp_a_vld",   32'(out_valid), 32'h1);
    chk("bp_a_data",  rdata1_out, 32'hAAAA_0001);
    chk("bp_a_rdy",   32'(in_ready), 32'h1);
    drive(1'b1, 32'hBBBB_0002, 1'b1);
    tick();
    chk("bp_full_rdy", 32'(in_ready), 32'h0);
    chk("bp_hold_a",  rdata1_out, 32'hAAAA_0001);
    chk("bp_hold_wen", 32'(wen_out), 32'h0);
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("bp_hold_a2", rdata1_out, 32'hAAAA_0001);
    chk("bp_hold_vld", 32'(out_valid), 32'h1);
    out_ready = 1'b1;
    tick();
    chk("bp_b_data",  rdata1_out, 32'hBBBB_0002);
    chk("bp_b_vld",   32'(out_valid), 32'h1);
    chk("bp_b_wen",   32'(wen_out), 32'h1);
    chk("bp_b_rdy",   32'(in_ready), 32'h1);
    tick();
    // B carried wen=1 and is still the stored payload: the bubble must mask it.
    chk("bub_vld",    32'(out_valid), 32'h0);
    chk("bub_wen",    32'(wen_out), 32'h0);

    // ---------------- flush from FULL ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'h1111, 1'b1);
    tick();
    drive(1'b1, 32'h2222, 1'b1);
    tick();
    chk("fl_full_rdy", 32'(in_ready), 32'h0);
    flush = 1'b1;
    drive(1'b1, 32'hDEAD, 1'b1);
    tick();
    chk("fl_vld",     32'(out_valid), 32'h0);
    chk("fl_wen",     32'(wen_out), 32'h0);
    chk("fl_rdy",     32'(in_ready), 32'h1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("fl_vld2",    32'(out_valid), 32'h0);
    chk("fl_no_dead", 32'(rdata1_out == 32'hDEAD), 32'h0);
    tick();
    chk("fl_vld3",    32'(out_valid), 32'h0);

    // ---------------- flush from BUSY with an accepted input ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'h3333, 1'b1);
    tick();
    chk("flb_busy_rdy", 32'(in_ready), 32'h1);
    flush = 1'b1;
    drive(1'b1, 32'hDEAD, 1'b1);
    tick();
    chk("flb_vld",    32'(out_valid), 32'h0);
    chk("flb_wen",    32'(wen_out), 32'h0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("flb_vld2",   32'(out_valid), 32'h0);
    chk("flb_no_dead", 32'(rdata1_out == 32'hDEAD), 32'h0);
    out_ready = 1'b1;
    drive(1'b1, 32'h4444, 1'b0);
    tick();
    chk("flb_rec_data", rdata1_out, 32'h4444);
    chk("flb_rec_vld", 32'(out_valid), 32'h1);
    drive(1'b0, 32'h0, 1'b0);
    tick();

    // ---------------- reset while stalled in FULL ----------------
    out_ready = 1'b0;
    drive(1'b1, 32'h5555, 1'b1);
    tick();
    drive(1'b1, 32'h6666, 1'b1);
    tick();
    rst = 1'b1;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("mrst_vld",   32'(out_valid), 32'h0);
    chk("mrst_data",  rdata1_out, 32'h0);
    chk("mrst_rdy",   32'(in_ready), 32'h1);
    rst = 1'b0;
    out_ready = 1'b1;
    tick();
    chk("mrst_vld2",  32'(out_valid), 32'h0);
    tick();
    chk("mrst_vld3",  32'(out_valid), 32'h0);

    // ---------------- plain register build (dut0) ----------------
    rst = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 32'h100, 1'b0);
    #1;
    chk("s0_rdy_empty", 32'(in_ready0), 32'h1);
    tick();
    chk("s0_d0",      rdata1_out0, 32'h100);
    chk("s0_vld0",    32'(out_valid0), 32'h1);
    chk("s0_rdy_flow", 32'(in_ready0), 32'h1);
    drive(1'b1, 32'h101, 1'b1);
    out_ready = 1'b0;
    #1;
    chk("s0_rdy_stall", 32'(in_ready0), 32'h0);
    tick();
    chk("s0_hold",    rdata1_out0, 32'h100);
    chk("s0_hold_vld", 32'(out_valid0), 32'h1);
    out_ready = 1'b1;
    #1;
    chk("s0_rdy_go",  32'(in_ready0), 32'h1);
    tick();
    chk("s0_d1",      rdata1_out0, 32'h101);
    chk("s0_wen1",    32'(wen_out0), 32'h1);
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("s0_drain_vld", 32'(out_valid0), 32'h0);
    chk("s0_drain_wen", 32'(wen_out0), 32'h0);
    chk("s0_drain_rdy", 32'(in_ready0), 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
